serial_word_deser: RTL and testbench

- Upstream feeder for the team's 16-bit word checkers (odd-bit parity check, 010-pattern check, multiple-of-3 check on a nibble).
- Takes a framed serial bitstream and assembles MSB-first WIDTH-bit words.
- Each completed word goes into a 2-entry output buffer and is presented on a valid/ready interface, so the combinational checkers can sample one stable word at a time.

---
 rtl/serial_word_deser.sv | 125 ++++++++++++
 tb/tb_serial_word_deser.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deser.sv
// Framed serial-to-parallel deserializer: assembles MSB-first WIDTH-bit words
// and presents them through a 2-entry valid/ready output buffer.
module serial_word_deser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] word;

  assign word = {shreg_q[WIDTH-2:0], bit_in};
  assign pop  = valid_q & out_ready;

  // sof always restarts a word, even on what would have been the final bit
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (bit_valid) begin
      if (sof) begin
        shreg_d = {{(WIDTH-1){1'b0}}, bit_in};
        cnt_d   = CW'(1);
        state_d = COLLECT;
      end else if (state_q == COLLECT) begin
        shreg_d = word;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          push  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Head register drives out_data directly and is zeroed whenever the buffer empties
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = word;
          count_d = 2'd1;
          valid_d = 1'b1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          head_d = word;
        end else if (pop) begin
          head_d  = '0;
          count_d = 2'd0;
          valid_d = 1'b0;
        end else if (push) begin
          tail_d  = word;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = push ? word : '0;
          count_d = push ? 2'd2 : 2'd1;
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_word_deser.sv
// Scoreboard bench for serial_word_deser: expected words are queued as they are
// sent and checked by a pop monitor; each scenario task adds its own inline checks.
module tb_serial_word_deser;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             bit_in;
  logic             bit_valid;
  logic             sof;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  int vectors;
  int miscompares;
  logic [WIDTH-1:0] sb[$];

  serial_word_deser #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .sof      (sof),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pop happens at the next rising edge whenever valid and ready are both high here
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_word;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pop_unexpected: got %h, required no word", out_data);
      end else begin
        exp_word = sb.pop_front();
        if (out_data !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL pop_data: got %h, required %h", out_data, exp_word);
        end
      end
    end
  end

  task automatic drive(input logic bv, input logic b, input logic s);
    bit_valid = bv;
    bit_in    = b;
    sof       = s;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic first_sof);
    for (int i = 0; i < WIDTH; i++)
      drive(1'b1, w[WIDTH-1-i], first_sof && (i == 0));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    rst = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h ovf=%b, required 0/0000/0",
               out_valid, out_data, overflow);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_word();
    logic [WIDTH-1:0] w;
    w = 16'hA5C3;
    out_ready = 1'b1;
    idle(3);
    sb.push_back(w);
    for (int i = 0; i < WIDTH - 1; i++) drive(1'b1, w[WIDTH-1-i], i == 0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_early_valid: got %b, required 0", out_valid);
    end
    drive(1'b1, w[0], 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== w) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got valid=%b data=%h, required 1/%h", out_valid, out_data, w);
    end
    idle(1);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL basic_after_pop: got valid=%b data=%h, required 0/0000", out_valid, out_data);
    end
  endtask

  task automatic test_idle_ignore();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ignore_valid: got %b, required 0", out_valid);
    end
    sb.push_back(16'h0F0F);
    send_word(16'h0F0F, 1'b1);
    wait_drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL idle_ignore_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    out_ready = 1'b0;
    sb.push_back(16'h1111);
    sb.push_back(16'h2222);
    send_word(16'h1111, 1'b1);
    send_word(16'h2222, 1'b0);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overflow_early: got %b, required 0", overflow);
    end
    send_word(16'h3333, 1'b0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_set: got %b, required 1", overflow);
    end
    out_ready = 1'b1;
    idle(3);
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_drain: got valid=%b pending=%0d ovf=%b, required 0/0/1",
               out_valid, sb.size(), overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    apply_reset();
    out_ready = 1'b0;
    sb.push_back(16'h1234);
    sb.push_back(16'h5678);
    sb.push_back(16'h9ABC);
    send_word(16'h1234, 1'b1);
    send_word(16'h5678, 1'b0);
    w = 16'h9ABC;
    for (int i = 0; i < WIDTH - 1; i++) drive(1'b1, w[WIDTH-1-i], 1'b0);
    out_ready = 1'b1;
    drive(1'b1, w[0], 1'b0);
    out_ready = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h5678) begin
      miscompares++;
      $display("[TB] FAIL full_pop_push: got ovf=%b valid=%b head=%h, required 0/1/5678",
               overflow, out_valid, out_data);
    end
    out_ready = 1'b1;
    wait_drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_pop_push_drain: got pending=%0d valid=%b, required 0/0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_resync();
    logic [WIDTH-1:0] w;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, i == 0);
    sb.push_back(16'hBEEF);
    send_word(16'hBEEF, 1'b1);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resync_mid: got pending=%0d ovf=%b, required 0/0", sb.size(), overflow);
    end
    w = 16'h7777;
    for (int i = 0; i < WIDTH - 1; i++) drive(1'b1, w[WIDTH-1-i], i == 0);
    drive(1'b1, 1'b1, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resync_last_bit: got valid=%b, required 0", out_valid);
    end
    w = 16'hC001;
    sb.push_back(w);
    for (int i = 1; i < WIDTH; i++) drive(1'b1, w[WIDTH-1-i], 1'b0);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resync_last_drain: got pending=%0d ovf=%b, required 0/0", sb.size(), overflow);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    sb.push_back(16'hAAAA);
    send_word(16'hAAAA, 1'b1);
    send_word(16'h5555, 1'b0);
    send_word(16'hFFFF, 1'b0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h5555 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_state: got valid=%b data=%h ovf=%b, required 1/5555/1",
               out_valid, out_data, overflow);
    end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, i == 0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got valid=%b data=%h ovf=%b, required 0/0000/0",
               out_valid, out_data, overflow);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(16'hFFFF, 1'b0);
    idle(2);
    vectors++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_ignore: got valid=%b ovf=%b, required 0/0", out_valid, overflow);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    sof         = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_basic_word();
    test_idle_ignore();
    test_overflow();
    test_back_to_back();
    test_resync();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
